// File: rtl/subsv_pkg.sv
// Shared types and elaboration helpers for the iterative subtractor subsv_iter.
package subsv_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Slice-counter width: clog2(number of slices), never narrower than one bit.
    function automatic int cnt_width(input int n, input int chunk);
        int w;
        w = $clog2(n / chunk);
        return (w < 1) ? 1 : w;
    endfunction

    function automatic bit params_legal(input int n, input int chunk);
        return (chunk > 0) && (n >= chunk) && ((n % chunk) == 0);
    endfunction

endpackage

// File: rtl/subsv_slice.sv
// Combinational CHUNK-bit adder slice; c_msb is the carry into the slice MSB.
module subsv_slice
    import subsv_pkg::*;
#(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             c_msb
);

    logic [CHUNK:0] full;

    assign full  = {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, cin};
    assign sum   = full[CHUNK-1:0];
    assign cout  = full[CHUNK];
    // Carry into the MSB recovered from the MSB sum bit and its two operand bits.
    assign c_msb = full[CHUNK-1] ^ x[CHUNK-1] ^ y[CHUNK-1];

endmodule

// File: rtl/subsv_iter.sv
// Iterative N-bit subtractor DIFF = A - B - BIN, CHUNK bits per clock.
// Optional compare flags ZERO/LT/LTU are built when SUBSV_ITER_CMP_EN is defined.
module subsv_iter
    import subsv_pkg::*;
#(
    parameter int N     = 32,
    parameter int CHUNK = 8
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic         START,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         BIN,
    output logic         BUSY,
    output logic         DONE,
    output logic [N-1:0] DIFF,
    output logic         BOUT,
`ifdef SUBSV_ITER_CMP_EN
    output logic         ZERO,
    output logic         LT,
    output logic         LTU,
`endif
    output logic         OVF
);

    localparam int M     = N / CHUNK;
    localparam int CNT_W = cnt_width(N, CHUNK);

    if (!params_legal(N, CHUNK)) begin : g_param_check
        $fatal(1, "subsv_iter: N (%0d) must be a positive multiple of CHUNK (%0d)", N, CHUNK);
    end

    state_t             state_q, state_nxt;
    logic [CNT_W-1:0]   cnt_q;
    logic [N-1:0]       a_q, b_q, res_q, res_nxt;
    logic               c_q, done_q, bout_q, ovf_q;
    logic [N-1:0]       diff_q;
    logic [CHUNK-1:0]   s_sum;
    logic               s_cout, s_cmsb, last;
    logic               accept;

    subsv_slice #(.CHUNK(CHUNK)) u_slice (
        .x     (a_q[CHUNK-1:0]),
        .y     (b_q[CHUNK-1:0]),
        .cin   (c_q),
        .sum   (s_sum),
        .cout  (s_cout),
        .c_msb (s_cmsb)
    );

    assign accept  = (state_q == IDLE) && START;
    assign last    = (state_q == RUN) && (cnt_q == CNT_W'(M - 1));
    // Slice sums enter at the top and walk down, so slice 0 ends up in the LSBs.
    assign res_nxt = (res_q >> CHUNK) | (N'(s_sum) << (N - CHUNK));

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state_q <= IDLE;
        else        state_q <= state_nxt;
    end

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            IDLE:    if (START) state_nxt = RUN;
            RUN:     if (last)  state_nxt = IDLE;
            default:            state_nxt = IDLE;
        endcase
    end

    always_comb begin
        BUSY = (state_q == RUN);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            a_q    <= '0;
            b_q    <= '0;
            c_q    <= 1'b0;
            cnt_q  <= '0;
            res_q  <= '0;
            diff_q <= '0;
            bout_q <= 1'b0;
            ovf_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                // Subtraction as A + ~B + ~BIN.
                a_q   <= A;
                b_q   <= ~B;
                c_q   <= ~BIN;
                cnt_q <= '0;
                res_q <= '0;
            end else if (state_q == RUN) begin
                a_q   <= a_q >> CHUNK;
                b_q   <= b_q >> CHUNK;
                c_q   <= s_cout;
                cnt_q <= cnt_q + CNT_W'(1);
                res_q <= res_nxt;
                if (last) begin
                    diff_q <= res_nxt;
                    bout_q <= ~s_cout;
                    ovf_q  <= s_cmsb ^ s_cout;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign DONE = done_q;
    assign DIFF = diff_q;
    assign BOUT = bout_q;
    assign OVF  = ovf_q;

`ifdef SUBSV_ITER_CMP_EN
    logic zacc_q, zero_q, lt_q, ltu_q;

    // Zero detect accumulates per slice so completion needs no wide reduction.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            zacc_q <= 1'b0;
            zero_q <= 1'b0;
            lt_q   <= 1'b0;
            ltu_q  <= 1'b0;
        end else if (accept) begin
            zacc_q <= 1'b0;
        end else if (state_q == RUN) begin
            zacc_q <= zacc_q | (|s_sum);
            if (last) begin
                zero_q <= ~(zacc_q | (|s_sum));
                lt_q   <= s_sum[CHUNK-1] ^ s_cmsb ^ s_cout;
                ltu_q  <= ~s_cout;
            end
        end
    end

    assign ZERO = zero_q;
    assign LT   = lt_q;
    assign LTU  = ltu_q;
`endif

endmodule

// File: tb/tb_subsv_iter.sv
// Self-checking bench for subsv_iter (N=32, CHUNK=8): vector table, random ops, handshake corners.
module tb_subsv_iter;

    localparam int N = 32;
    localparam int M = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [N-1:0]  a_i, b_i;
    logic          bin_i;
    logic          busy, done, bout, ovf;
    logic [N-1:0]  diff;
`ifdef SUBSV_ITER_CMP_EN
    logic          zero, lt, ltu;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    subsv_iter #(.N(N), .CHUNK(8)) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .START (start),
        .A     (a_i),
        .B     (b_i),
        .BIN   (bin_i),
        .BUSY  (busy),
        .DONE  (done),
        .DIFF  (diff),
        .BOUT  (bout),
`ifdef SUBSV_ITER_CMP_EN
        .ZERO  (zero),
        .LT    (lt),
        .LTU   (ltu),
`endif
        .OVF   (ovf)
    );

    typedef struct {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic         bin;
        logic [N-1:0] diff;
        logic         bout;
        logic         ovf;
        logic         zero;
        logic         lt;
        logic         ltu;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the mathematical values.
    function automatic vec_t model(input logic [N-1:0] a, input logic [N-1:0] b, input logic bin);
        vec_t   v;
        longint ua, ub, sa, sb, sd;
        ua = longint'({32'h0, a});
        ub = longint'({32'h0, b});
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        sd = sa - sb - longint'(bin);
        v.a    = a;
        v.b    = b;
        v.bin  = bin;
        v.diff = N'(ua - ub - longint'(bin));
        v.bout = (ua < ub + longint'(bin));
        v.ovf  = (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
        v.zero = (v.diff == '0);
        v.lt   = (sa < sb + longint'(bin));
        v.ltu  = v.bout;
        return v;
    endfunction

    // Issue one operation (caller is just past a rising edge, DUT idle) and wait for DONE.
    task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic bin,
                         output int cyc, output bit busy_ok);
        a_i = a; b_i = b; bin_i = bin; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0;
        busy_ok = 1'b1;
        while (!done && cyc < 20) begin
            if (!busy) busy_ok = 1'b0;
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic check_result(input string nm, input vec_t e, input int cyc, input bit busy_ok);
        chk({nm, "_latency"}, 64'(cyc), 64'(M));
        chk({nm, "_busy_run"}, 64'(busy_ok), 64'd1);
        chk({nm, "_busy_done"}, 64'(busy), 64'd0);
        chk({nm, "_diff"}, 64'(diff), 64'(e.diff));
        chk({nm, "_bout"}, 64'(bout), 64'(e.bout));
        chk({nm, "_ovf"}, 64'(ovf), 64'(e.ovf));
`ifdef SUBSV_ITER_CMP_EN
        chk({nm, "_zero"}, 64'(zero), 64'(e.zero));
        chk({nm, "_lt"}, 64'(lt), 64'(e.lt));
        chk({nm, "_ltu"}, 64'(ltu), 64'(e.ltu));
`endif
    endtask

    vec_t tbl[7];

    initial begin
        int    cyc;
        bit    bok;
        bit    seen;
        vec_t  e;

        //          a             b             bin   diff          bout  ovf   zero  lt    ltu
        tbl[0] = '{32'h00000005, 32'h00000003, 1'b0, 32'h00000002, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{32'h00000000, 32'h00000001, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[2] = '{32'h80000000, 32'h00000001, 1'b0, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[3] = '{32'h00000010, 32'h00000010, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[4] = '{32'h00000010, 32'h00000010, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[5] = '{32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h80000000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[6] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

        rst_n = 1'b0; start = 1'b0; a_i = '0; b_i = '0; bin_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_diff", 64'(diff), 64'd0);
        chk("rst_bout", 64'(bout), 64'd0);
        chk("rst_ovf", 64'(ovf), 64'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 7; i++) begin
            do_op(tbl[i].a, tbl[i].b, tbl[i].bin, cyc, bok);
            check_result($sformatf("vec%0d", i), tbl[i], cyc, bok);
        end

        for (int i = 0; i < 40; i++) begin
            logic [N-1:0] ra, rb;
            logic         rbin;
            ra = $urandom;
            rb = (i % 8 == 0) ? ra : $urandom;
            rbin = 1'($urandom_range(0, 1));
            e = model(ra, rb, rbin);
            do_op(ra, rb, rbin, cyc, bok);
            check_result($sformatf("rnd%0d", i), e, cyc, bok);
        end

        // START while busy is ignored; a START in the DONE cycle is accepted.
        a_i = 32'd9; b_i = 32'd4; bin_i = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        a_i = 32'd1; b_i = 32'd1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; a_i = '0; b_i = '0;
        cyc = 2;
        while (!done && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("b2b_first_latency", 64'(cyc), 64'(M));
        chk("b2b_first_diff", 64'(diff), 64'd5);
        do_op(32'd20, 32'd6, 1'b0, cyc, bok);
        e = model(32'd20, 32'd6, 1'b0);
        check_result("b2b_third", e, cyc, bok);
        @(posedge clk); #1;
        chk("b2b_done_pulse", 64'(done), 64'd0);
        chk("b2b_diff_hold", 64'(diff), 64'd14);

        // Asynchronous reset mid-operation aborts it with no DONE.
        a_i = 32'd100; b_i = 32'd50; bin_i = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_diff", 64'(diff), 64'd0);
        chk("abort_bout", 64'(bout), 64'd0);
        chk("abort_ovf", 64'(ovf), 64'd0);
        @(negedge clk); rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (done || busy) seen = 1'b1;
        end
        chk("abort_no_done", 64'(seen), 64'd0);
        do_op(32'd10, 32'd7, 1'b0, cyc, bok);
        e = model(32'd10, 32'd7, 1'b0);
        check_result("after_abort", e, cyc, bok);
        chk("after_abort_diff3", 64'(diff), 64'd3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
